// File: rtl/fp_mult_result_buf_if.sv
// Handshake bundle between the multiplier, the result buffer and its consumer.
// master = upstream/consumer side, slave = the buffer itself.
interface fp_mult_result_buf_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;

  modport master (
    output in_valid, in_z, in_status, out_ready,
    input  in_ready, out_valid, out_z, out_status
  );

  modport slave (
    input  in_valid, in_z, in_status, out_ready,
    output in_ready, out_valid, out_z, out_status
  );
endinterface

// File: rtl/fp_mult_result_buf.sv
// First-word-fall-through result buffer for the FP multiplier with sticky exception flags.
// Optional inexact-event counter enabled by defining FP_RESULT_CNT_EN.
module fp_mult_result_buf #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  fp_mult_result_buf_if.slave          bus,
  input  logic                         flags_clr,
  output logic [5:0]                   sticky_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             inexact_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]      r_mem_z  [DEPTH];
  logic [5:0]       r_mem_st [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [5:0]       r_sticky;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_unused_status;

  // Top two status bits carry no information and are dropped at the input.
  assign w_unused_status = ^bus.in_status[7:6];

  assign w_full        = (r_count == FULL_COUNT);
  assign bus.in_ready  = rst & ~w_full;
  assign bus.out_valid = (r_count != '0);
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;

  assign bus.out_z      = r_mem_z[r_rd_ptr];
  assign bus.out_status = {2'b00, r_mem_st[r_rd_ptr]};
  assign count          = r_count;
  assign sticky_flags   = r_sticky;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_z[r_wr_ptr]  <= bus.in_z;
      r_mem_st[r_wr_ptr] <= bus.in_status[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_sticky <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Flags raised by the pushing result survive a clear issued in the same cycle.
      r_sticky <= (flags_clr ? 6'h00 : r_sticky) | (w_push ? bus.in_status[5:0] : 6'h00);
    end
  end

`ifdef FP_RESULT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_inexact_cnt;
  logic [CNT_W-1:0] w_cnt_base;

  assign w_cnt_base  = flags_clr ? '0 : r_inexact_cnt;
  assign inexact_cnt = r_inexact_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inexact_cnt <= '0;
    end else if (w_push && bus.in_status[5] && (w_cnt_base != CNT_MAX)) begin
      r_inexact_cnt <= w_cnt_base + 1'b1;
    end else begin
      r_inexact_cnt <= w_cnt_base;
    end
  end
`else
  assign inexact_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_mult_result_buf.sv
// Self-checking bench for fp_mult_result_buf against a queue-based reference model.
// Expectations for inexact_cnt follow FP_RESULT_CNT_EN.
module tb_fp_mult_result_buf;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] z;
    logic [5:0]  st;
  } ent_t;

  logic                        clk;
  logic                        rst;
  logic                        flags_clr;
  logic [5:0]                  sticky_flags;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic [CNT_W-1:0]            inexact_cnt;

  fp_mult_result_buf_if bus ();

  fp_mult_result_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .count        (count),
    .inexact_cnt  (inexact_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  ent_t       q[$];
  logic [5:0] m_sticky;
  int         m_cnt;
  bit         last_push;
  bit         last_pop;
  bit         m_rst;

  int n_cmp = 0;
  int n_err = 0;

  // Apply one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic drive(input bit r, input bit v, input logic [31:0] z, input logic [7:0] st,
                       input bit ordy, input bit clr);
    ent_t e;
    @(negedge clk);
    rst           = r;
    m_rst         = r;
    bus.in_valid  = v;
    bus.in_z      = z;
    bus.in_status = st;
    bus.out_ready = ordy;
    flags_clr     = clr;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_sticky  = 6'h00;
      m_cnt     = 0;
      last_push = 1'b0;
      last_pop  = 1'b0;
    end else begin
      last_push = v && (q.size() != DEPTH);
      last_pop  = ordy && (q.size() != 0);
      if (last_pop) void'(q.pop_front());
      if (last_push) begin
        e.z  = z;
        e.st = st[5:0];
        q.push_back(e);
      end
      m_sticky = (clr ? 6'h00 : m_sticky) | (last_push ? st[5:0] : 6'h00);
`ifdef FP_RESULT_CNT_EN
      if (clr) m_cnt = 0;
      if (last_push && st[5] && m_cnt < CNT_MAX) m_cnt++;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'hDEAD0000 + 32'(i), 8'h3F, 1'b1, 1'b0);
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); n_err++;
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", i, bus.out_valid); n_err++;
      end
      n_cmp++;
      if (count !== '0) begin
        $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, count); n_err++;
      end
      n_cmp++;
      if (sticky_flags !== 6'h00) begin
        $display("FAIL reset_sticky cyc=%0d got=%h exp=00", i, sticky_flags); n_err++;
      end
      n_cmp++;
      if (inexact_cnt !== '0) begin
        $display("FAIL reset_inexact_cnt cyc=%0d got=%0d exp=0", i, inexact_cnt); n_err++;
      end
    end
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); n_err++;
    end
    $display("test_reset done: %0d compared so far", n_cmp);
  endtask

  task automatic test_single_pass();
    drive(1'b1, 1'b1, 32'h40C00000, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); n_err++;
    end
    n_cmp++;
    if (bus.out_z !== 32'h40C00000) begin
      $display("FAIL single_out_z got=%h exp=40c00000", bus.out_z); n_err++;
    end
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (count !== '0 || bus.out_valid !== 1'b0) begin
      $display("FAIL single_drain count=%0d out_valid=%b exp=0/0", count, bus.out_valid); n_err++;
    end
    $display("test_single_pass done: %0d compared so far", n_cmp);
  endtask

  task automatic test_fill();
    int  k;
    bit  sent5;
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'(i), 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (count !== 3'(i)) begin
        $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); n_err++;
      end
    end
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL fill_full_ready got=%b exp=0", bus.in_ready); n_err++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'd5, 8'h00, 1'b0, 1'b0);
      n_cmp++;
      if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
        $display("FAIL fill_hold count=%0d in_ready=%b exp=4/0", count, bus.in_ready); n_err++;
      end
    end
    k = 0;
    sent5 = 1'b0;
    for (int c = 0; c < 15 && k < 5; c++) begin
      if (q.size() != 0) begin
        n_cmp++;
        if (bus.out_z !== 32'(k + 1)) begin
          $display("FAIL fill_order idx=%0d got=%h exp=%h", k, bus.out_z, 32'(k + 1)); n_err++;
        end
        k++;
      end
      drive(1'b1, !sent5, 32'd5, 8'h00, 1'b1, 1'b0);
      if (last_push) sent5 = 1'b1;
      n_cmp++;
      if (count > 3'd4) begin
        $display("FAIL fill_overcount got=%0d exp<=4", count); n_err++;
      end
    end
    n_cmp++;
    if (k != 5 || count !== '0) begin
      $display("FAIL fill_total popped=%0d count=%0d exp=5/0", k, count); n_err++;
    end
    $display("test_fill done: %0d compared so far", n_cmp);
  endtask

  task automatic test_sticky();
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 32'h11111111, 8'h20, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h22222222, 8'h04, 1'b1, 1'b0);
    n_cmp++;
    if (sticky_flags !== 6'h24) begin
      $display("FAIL sticky_accum got=%h exp=24", sticky_flags); n_err++;
    end
    n_cmp++;
    if (bus.out_status !== 8'h04) begin
      $display("FAIL sticky_out_status got=%h exp=04", bus.out_status); n_err++;
    end
    drive(1'b1, 1'b1, 32'h33333333, 8'h01, 1'b1, 1'b1);
    n_cmp++;
    if (sticky_flags !== 6'h01) begin
      $display("FAIL sticky_clr_push got=%h exp=01", sticky_flags); n_err++;
    end
    drive(1'b1, 1'b1, 32'h44444444, 8'hC0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.out_status !== 8'h00 || bus.out_z !== 32'h44444444) begin
      $display("FAIL sticky_mask z=%h status=%h exp=44444444/00", bus.out_z, bus.out_status); n_err++;
    end
    n_cmp++;
    if (sticky_flags !== 6'h01) begin
      $display("FAIL sticky_after_mask got=%h exp=01", sticky_flags); n_err++;
    end
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    n_cmp++;
    if (sticky_flags !== 6'h01) begin
      $display("FAIL sticky_pop_keeps got=%h exp=01", sticky_flags); n_err++;
    end
    $display("test_sticky done: %0d compared so far", n_cmp);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
    drive(1'b1, 1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (bus.out_z !== q[0].z || bus.out_status !== {2'b00, q[0].st}) begin
        $display("FAIL b2b_head cyc=%0d got=%h/%h exp=%h/%h", i, bus.out_z, bus.out_status,
                 q[0].z, {2'b00, q[0].st});
        n_err++;
      end
      drive(1'b1, 1'b1, $urandom, 8'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (count !== 3'd2) begin
        $display("FAIL b2b_count cyc=%0d got=%0d exp=2", i, count); n_err++;
      end
    end
    for (int i = 0; i < DEPTH + 1 && q.size() != 0; i++)
      drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    $display("test_back_to_back done: %0d compared so far", n_cmp);
  endtask

  task automatic test_inexact_cnt();
    int exp_final;
`ifdef FP_RESULT_CNT_EN
    exp_final = CNT_MAX;
`else
    exp_final = 0;
`endif
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, $urandom, 8'h20, 1'b1, 1'b0);
      n_cmp++;
      if (inexact_cnt !== CNT_W'(m_cnt)) begin
        $display("FAIL cnt_step i=%0d got=%0d exp=%0d", i, inexact_cnt, m_cnt); n_err++;
      end
    end
    n_cmp++;
    if (inexact_cnt !== CNT_W'(exp_final)) begin
      $display("FAIL cnt_saturate got=%0d exp=%0d", inexact_cnt, exp_final); n_err++;
    end
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
    n_cmp++;
    if (inexact_cnt !== '0) begin
      $display("FAIL cnt_clear got=%0d exp=0", inexact_cnt); n_err++;
    end
    $display("test_inexact_cnt done: %0d compared so far", n_cmp);
  endtask

  task automatic test_random();
    bit r, v, ordy, clr;
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(0, 59) != 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 11) == 0);
      drive(r, v, $urandom, 8'($urandom), ordy, clr);
      n_cmp++;
      if (bus.in_ready !== (m_rst && q.size() != DEPTH) ||
          bus.out_valid !== (q.size() != 0) || count !== 3'(q.size())) begin
        $display("FAIL rnd_ctrl cyc=%0d in_ready=%b out_valid=%b count=%0d exp=%b/%b/%0d", i,
                 bus.in_ready, bus.out_valid, count, m_rst && q.size() != DEPTH,
                 q.size() != 0, q.size());
        n_err++;
      end
      n_cmp++;
      if (sticky_flags !== m_sticky || inexact_cnt !== CNT_W'(m_cnt)) begin
        $display("FAIL rnd_flags cyc=%0d sticky=%h cnt=%0d exp=%h/%0d", i, sticky_flags,
                 inexact_cnt, m_sticky, m_cnt);
        n_err++;
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (bus.out_z !== q[0].z || bus.out_status !== {2'b00, q[0].st}) begin
          $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, bus.out_z, bus.out_status,
                   q[0].z, {2'b00, q[0].st});
          n_err++;
        end
      end
    end
    $display("test_random done: %0d compared so far", n_cmp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b0;
    m_rst         = 1'b0;
    flags_clr     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_z      = 32'h0;
    bus.in_status = 8'h00;
    bus.out_ready = 1'b0;
    m_sticky      = 6'h00;
    m_cnt         = 0;
    test_reset();
    test_single_pass();
    test_fill();
    test_sticky();
    test_back_to_back();
    test_inexact_cnt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
